// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write arbiter/sequencer sharing one enable-gated register bank among NREQ requesters.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module dff_bank_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    reg_en,
    output logic [WIDTH-1:0]        reg_d,
    output logic                    busy,
    output logic [IDW-1:0]          last_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_ack;
    logic               r_en;
    logic               r_busy;
    logic [WIDTH-1:0]   r_d;
    logic [IDW-1:0]     r_win;
    logic [IDW-1:0]     r_last;
`ifndef ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     r_ptr;
`endif

    logic               w_any;
    logic [IDW-1:0]     w_win;
    logic [NREQ-1:0]    w_win_oh;
    logic [WIDTH-1:0]   w_wdata;

    assign w_any = |req;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win = IDW'(i);
            end
        end
    end
`else
    // Lowest requester above the pointer wins; failing that, wrap to the lowest at or below it.
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IDW'(i) <= r_ptr)) begin
                w_win = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IDW'(i) > r_ptr)) begin
                w_win = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_win_oh = '0;
        w_wdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_oh[i] = 1'b1;
                w_wdata     = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_d     <= '0;
            r_win   <= '0;
            r_last  <= IDW'(NREQ - 1);
`ifndef ARB_FIXED_PRIO_EN
            r_ptr   <= IDW'(NREQ - 1);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_d     <= w_wdata;
                        r_gnt   <= w_win_oh;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_win   <= w_win;
                        r_state <= S_WRITE;
                    end else begin
                        r_gnt  <= '0;
                        r_en   <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                // The bank samples r_d at the end of this cycle; the grant becomes the ack.
                S_WRITE: begin
                    r_en    <= 1'b0;
                    r_gnt   <= '0;
                    r_ack   <= r_gnt;
                    r_last  <= r_win;
`ifndef ARB_FIXED_PRIO_EN
                    r_ptr   <= r_win;
`endif
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign reg_en  = r_en;
    assign reg_d   = r_d;
    assign busy    = r_busy;
    assign last_id = r_last;

endmodule

// File: doc/dff_bank_write_arbiter.md
Name: dff_bank_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one enable-gated D-register bank (d/en/q storage) between NREQ requesters.
- Captures the winning requester's data and drives the bank's d/en for exactly one cycle.
- Returns a one-cycle ack to the winner.
- Sits between requester logic and the shared storage register in the latch/flip-flop datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of the shared register bank.
- IDW, 2, width of the grant index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request; level, held until ack.
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]; held stable while req[i]=1.
- gnt  output  NREQ  one-hot grant, high during the write cycle.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- reg_en  output  1  enable to the shared register bank.
- reg_d  output  WIDTH  data to the shared register bank.
- busy  output  1  high whenever the FSM is not IDLE.
- last_id  output  IDW  index of the most recently completed winner.

Behaviour:
- Reset (async, immediate):
  - gnt=0, ack=0, reg_en=0, reg_d=0, busy=0, last_id=NREQ-1.
  - FSM=IDLE; rr pointer=NREQ-1, so req[0] has top priority first.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, WRITE, ACK.
- IDLE, on a clock edge with any req bit set:
  - Winner = first set req scanning from (ptr+1) mod NREQ upward, with wrap-around.
  - Capture the winner's wdata slice into reg_d.
  - gnt[winner]<=1, reg_en<=1, busy<=1; go to WRITE.
  - With no req set: stay in IDLE; outputs hold reg_d, all other outputs 0.
- WRITE (exactly 1 cycle):
  - reg_en=1, gnt one-hot; the bank samples reg_d at the end of this cycle.
  - Next: reg_en<=0, gnt<=0, ack[winner]<=1, ptr<=winner, last_id<=winner; go to ACK.
- ACK (exactly 1 cycle):
  - ack pulse is high.
  - Next: ack<=0, busy<=0; go to IDLE.
- Latency: req seen at edge k -> reg_en/gnt high in cycle k+1 -> ack high in cycle k+2 -> arbitration again at edge k+3.
  - Peak throughput is 1 write per 3 cycles.
- Requester protocol:
  - Deassert req in the cycle after ack is seen.
  - A req still high at the IDLE edge is a new request.
  - Round-robin places it after every other pending requester.
- req dropped during WRITE/ACK: the transaction still completes and ack is still issued; data already captured is used.
- wdata changing after capture has no effect on the current write.
- Simultaneous requests: exactly one winner per arbitration; no requester waits more than NREQ-1 other grants.
- Reset asserted mid-WRITE or mid-ACK:
  - Transaction aborts and no ack is issued.
  - reg_en drops immediately (asynchronously).
- gnt, ack and reg_en are never high in the same cycle as each other except gnt with reg_en.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - Round-robin is replaced by fixed priority: lowest index wins.
  - ptr is unused (not updated); last_id still updates.
- Undefined: round-robin as described above.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset then single request: req=4'b0100, wdata[23:16]=8'hA5 at edge k -> reg_en=1, gnt=4'b0100, reg_d=8'hA5 in cycle k+1; ack=4'b0100 in k+2; busy low in k+3; last_id=2.
- All requesters constant: req=4'b1111, distinct data 8'h10/8'h21/8'h32/8'h43, each dropping req after its ack and re-raising 1 cycle later -> grant order 0,1,2,3,0; one write every 3 cycles. With ARB_FIXED_PRIO_EN the order is 0,0,0...
- Data capture: change wdata[7:0] from 8'h3C to 8'hFF in the WRITE cycle -> reg_d stays 8'h3C throughout.
- Req withdrawal: drop req[1] during its WRITE cycle -> ack[1] still pulses 1 cycle later; no second grant to requester 1.
- Async reset: assert reset mid-WRITE between clock edges -> reg_en, gnt and busy go 0 before the next edge; no ack; after release, req=4'b1000 wins with the pointer restored to NREQ-1.
- Idle stability: req=0 for 20 cycles -> reg_en, gnt and ack stay 0; reg_d holds the last written value.
